uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter p_CLK_DIV, default 104, meaning internal clock cycles per baud period (legal minimum 2).
REQ-002 SHALL have parameter p_WORD_LEN, default 8, meaning data bits per frame, sent LSB first.
REQ-003 SHALL have parameter p_STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-004 SHALL have port i_clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have port i_send_en, input, 1 bit, host request to queue a word.
REQ-007 SHALL have port i_send_data, input, p_WORD_LEN bits, word to queue.
REQ-008 SHALL have port o_send_rdy, output, 1 bit, high when the holding register is empty and a word can be accepted.
REQ-009 SHALL have port o_tx, output, 1 bit, registered serial line, idle high.
REQ-010 SHALL have port o_busy, output, 1 bit, high while a frame is on the line or a word is held.

Function
REQ-011 SHALL contain a one-word holding register (data plus valid flag) and a separate shift register, so one word can be queued while another is shifted out.
REQ-012 SHALL drive o_send_rdy as the inverse of the holding valid flag.
REQ-013 SHALL accept a word on a rising edge where i_rst_n=1, i_send_en=1 and o_send_rdy=1, capturing i_send_data and setting the valid flag.
REQ-014 SHALL ignore i_send_en while o_send_rdy=0; the held word is neither overwritten nor dropped.
REQ-015 SHALL implement states IDLE, START, DATA and STOP.
REQ-016 In IDLE with hold valid, SHALL load the held word into the shift register, clear the valid flag, clear the baud and bit counters, and enter START on the same edge.
REQ-017 SHALL drive o_tx low for exactly p_CLK_DIV cycles in START, then enter DATA.
REQ-018 In DATA, SHALL drive o_tx with each shift register bit, LSB first, for exactly p_CLK_DIV cycles each, for p_WORD_LEN bits, then enter STOP.
REQ-019 SHALL drive o_tx high in STOP for exactly p_STOP_BITS*p_CLK_DIV cycles.
REQ-020 At the end of STOP with hold valid, SHALL perform the REQ-016 load and enter START directly, with no idle cycle between frames.
REQ-021 At the end of STOP with hold empty, SHALL enter IDLE.
REQ-022 Latency: for an accept on edge N while IDLE, o_tx SHALL be low from edge N+1, and the full frame SHALL span (1+p_WORD_LEN+p_STOP_BITS)*p_CLK_DIV cycles.
REQ-023 SHALL allow an accept on the edge after a hold-to-shifter transfer, because o_send_rdy returns high at that point.
REQ-024 SHALL size the baud counter as $clog2(p_CLK_DIV*p_STOP_BITS+1) bits and the bit counter as $clog2(p_WORD_LEN+1) bits; neither counter may wrap within a frame.
REQ-025 SHALL drive o_busy high when state is not IDLE or hold is valid.
REQ-026 In any undefined state encoding, SHALL go to IDLE with o_tx=1.

Reset
REQ-027 With i_rst_n=0 at a rising edge, SHALL set state to IDLE, o_tx=1, hold valid=0 (o_send_rdy=1), o_busy=0, and both counters to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame, discard both the shifted and held words, and return o_tx high on the next edge.
REQ-029 SHALL ignore i_send_en on any edge where i_rst_n=0.

Verification (p_CLK_DIV=4, p_WORD_LEN=8, p_STOP_BITS=1 unless noted)
REQ-030 Single word: send 0xA5 from idle -> o_tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; 40 cycles total; o_busy then falls.
REQ-031 Back-to-back: send 0x00, then send 0xFF as soon as o_send_rdy rises -> second start bit immediately follows the first stop bit; 80 contiguous cycles; no extra idle cycle.
REQ-032 Backpressure: hold i_send_en=1 with changing data while o_send_rdy=0 -> only the first accepted and first queued words appear on o_tx; others are ignored.
REQ-033 Two stop bits: p_STOP_BITS=2, send 0x3C -> stop high 8 cycles; frame 44 cycles.
REQ-034 Reset mid-frame: assert i_rst_n=0 during DATA bit 3 with a word held -> next edge gives o_tx=1, o_send_rdy=1, o_busy=0; after release, the held word is never transmitted.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one-word holding register feeding a shift register, framed
// as start bit, p_WORD_LEN data bits LSB first, then p_STOP_BITS stop bits.
module uart_tx #(
   parameter int p_CLK_DIV   = 104,
   parameter int p_WORD_LEN  = 8,
   parameter int p_STOP_BITS = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_send_en,
   input  logic [p_WORD_LEN-1:0] i_send_data,
   output logic                  o_send_rdy,
   output logic                  o_tx,
   output logic                  o_busy
);

   localparam int BAUD_W = $clog2(p_CLK_DIV * p_STOP_BITS + 1);
   localparam int BIT_W  = $clog2(p_WORD_LEN + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(p_CLK_DIV - 1);
   localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(p_CLK_DIV * p_STOP_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(p_WORD_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t                state_q;
   logic [BAUD_W-1:0]     baud_cnt_q;
   logic [BIT_W-1:0]      bit_cnt_q;
   // One spare top bit (filled with 1) keeps shift_q[1] legal for any word length.
   logic [p_WORD_LEN:0]   shift_q;
   logic                  tx_q;
   logic                  hold_vld_q;
   logic [p_WORD_LEN-1:0] hold_data_q;

   logic                  hold_vld_d;
   logic [p_WORD_LEN-1:0] hold_data_d;
   logic                  accept;
   logic                  stop_end;
   logic                  load;

   always_comb begin
      accept      = i_send_en && !hold_vld_q;
      stop_end    = (state_q == S_STOP) && (baud_cnt_q == STOP_LAST);
      load        = hold_vld_q && ((state_q == S_IDLE) || stop_end);
      hold_vld_d  = hold_vld_q;
      hold_data_d = hold_data_q;
      if (accept) begin
         hold_vld_d  = 1'b1;
         hold_data_d = i_send_data;
      end else if (load) begin
         hold_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         baud_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '1;
         tx_q        <= 1'b1;
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
      end else begin
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  state_q    <= S_START;
                  shift_q    <= {1'b1, hold_data_q};
                  baud_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  tx_q       <= 1'b0;
               end else begin
                  tx_q       <= 1'b1;
               end
            end
            S_START: begin
               if (baud_cnt_q == BAUD_LAST) begin
                  baud_cnt_q <= '0;
                  state_q    <= S_DATA;
                  tx_q       <= shift_q[0];
               end else begin
                  baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (baud_cnt_q == BAUD_LAST) begin
                  baud_cnt_q <= '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= S_STOP;
                     tx_q      <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                     shift_q   <= {1'b1, shift_q[p_WORD_LEN:1]};
                     tx_q      <= shift_q[1];
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (stop_end) begin
                  baud_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  // Chain straight into the next start bit when a word is waiting.
                  if (hold_vld_q) begin
                     state_q <= S_START;
                     shift_q <= {1'b1, hold_data_q};
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     tx_q    <= 1'b1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
               end
            end
            default: begin
               state_q    <= S_IDLE;
               baud_cnt_q <= '0;
               bit_cnt_q  <= '0;
               tx_q       <= 1'b1;
            end
         endcase
      end
   end

   assign o_send_rdy = ~hold_vld_q;
   assign o_tx       = tx_q;
   assign o_busy     = (state_q != S_IDLE) || hold_vld_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits, CLK_DIV=4, 8-bit words)
// checked every cycle against a queue-based line model, plus literal spot checks.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] data;
   logic [1:0] tx, rdy, busy;

   int  vectors     = 0;
   int  miscompares = 0;
   bit  chk_en      = 1'b0;

   always #5 clk = ~clk;

   uart_tx #(.p_CLK_DIV(4), .p_WORD_LEN(8), .p_STOP_BITS(1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_send_en(en), .i_send_data(data),
      .o_send_rdy(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]));

   uart_tx #(.p_CLK_DIV(4), .p_WORD_LEN(8), .p_STOP_BITS(2)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_send_en(en), .i_send_data(data),
      .o_send_rdy(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]));

   task automatic check(input string nm, input logic got, input logic exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %b, expected %b", nm, $time, got, exp);
      end
   endtask

   // Model: a queue of per-cycle line levels; a frame is appended when the
   // line is free and a word is held. Index d selects stop-bit count d+1.
   bit         mq [2][$];
   bit         m_hv [2]  = '{1'b0, 1'b0};
   logic [7:0] m_hd [2]  = '{8'h00, 8'h00};
   bit         m_tx [2]  = '{1'b1, 1'b1};
   bit         m_inf [2] = '{1'b0, 1'b0};
   bit         m_hv0, m_b;
   logic [7:0] m_w;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            mq[d].delete();
            m_hv[d]  = 1'b0;
            m_tx[d]  = 1'b1;
            m_inf[d] = 1'b0;
         end else begin
            m_hv0 = m_hv[d];
            if (mq[d].size() == 0 && m_hv[d]) begin
               m_w = m_hd[d];
               for (int i = 0; i < 10 + d; i++) begin
                  if (i == 0)      m_b = 1'b0;
                  else if (i <= 8) m_b = m_w[i-1];
                  else             m_b = 1'b1;
                  repeat (4) mq[d].push_back(m_b);
               end
               m_hv[d] = 1'b0;
            end
            if (mq[d].size() > 0) begin
               m_tx[d]  = mq[d].pop_front();
               m_inf[d] = 1'b1;
            end else begin
               m_tx[d]  = 1'b1;
               m_inf[d] = 1'b0;
            end
            if (en && !m_hv0) begin
               m_hv[d] = 1'b1;
               m_hd[d] = data;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("tx_dut%0d", d),   tx[d],   m_tx[d]);
            check($sformatf("rdy_dut%0d", d),  rdy[d],  !m_hv[d]);
            check($sformatf("busy_dut%0d", d), busy[d], m_inf[d] | m_hv[d]);
         end
      end
   end

   task automatic wait_idle();
      for (int k = 0; k < 500 && busy != 2'b00; k++) @(negedge clk);
      check("wait_idle_timeout", |busy, 1'b0);
   endtask

   task automatic wait_rdy0();
      for (int k = 0; k < 100 && !rdy[0]; k++) @(negedge clk);
      check("wait_rdy_timeout", rdy[0], 1'b1);
   endtask

   initial begin
      logic [9:0]  a5_frame;
      logic [7:0]  held;
      logic        fr [40];
      int          lowcnt;

      rst_n = 1'b0;
      en    = 1'b1;
      data  = 8'h77;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_tx",   tx[d],   1'b1);
         check("reset_rdy",  rdy[d],  1'b1);
         check("reset_busy", busy[d], 1'b0);
      end
      rst_n = 1'b1;
      en    = 1'b0;
      repeat (3) @(negedge clk);

      // Single word 0xA5: start, 1,0,1,0,0,1,0,1, stop
      a5_frame = 10'b1_1010_0101_0;
      en = 1'b1; data = 8'hA5;
      @(posedge clk);
      @(negedge clk); en = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         fr[k] = tx[0];
      end
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < 4; j++)
            check($sformatf("a5_bit%0d", i), fr[i*4+j], a5_frame[i]);
      @(negedge clk);
      check("a5_busy_fall", busy[0], 1'b0);
      check("stop2_busy_hold", busy[1], 1'b1);
      repeat (4) @(negedge clk);
      check("stop2_busy_fall", busy[1], 1'b0);

      // Back-to-back 0x00 then 0xFF, no gap between frames
      wait_idle();
      @(negedge clk);
      en = 1'b1; data = 8'h00;
      @(posedge clk);
      @(negedge clk); en = 1'b0;
      wait_rdy0();
      en = 1'b1; data = 8'hFF;
      @(posedge clk);
      @(negedge clk); en = 1'b0;
      repeat (38) @(negedge clk);
      check("b2b_first_stop", tx[0], 1'b1);
      @(negedge clk);
      check("b2b_second_start", tx[0], 1'b0);
      repeat (39) @(negedge clk);
      check("b2b_last_stop", tx[0], 1'b1);
      check("b2b_busy_end", busy[0], 1'b1);
      @(negedge clk);
      check("b2b_busy_fall", busy[0], 1'b0);

      // Backpressure: en held high, data changing every cycle
      wait_idle();
      @(negedge clk);
      en = 1'b1; data = 8'h11;
      @(posedge clk);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         data = data + 8'h11;
      end
      en = 1'b0;
      held = 8'h33;
      repeat (17) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp_held_bit%0d", i), tx[0], held[i]);
         repeat (4) @(negedge clk);
      end

      // Reset during data bit 3 with a word held
      wait_idle();
      @(negedge clk);
      en = 1'b1; data = 8'h5A;
      @(posedge clk);
      @(negedge clk); en = 1'b0;
      wait_rdy0();
      en = 1'b1; data = 8'hC3;
      @(posedge clk);
      @(negedge clk); en = 1'b0;
      repeat (16) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("midrst_tx",   tx[d],   1'b1);
         check("midrst_rdy",  rdy[d],  1'b1);
         check("midrst_busy", busy[d], 1'b0);
      end
      rst_n = 1'b1;
      lowcnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx != 2'b11) lowcnt++;
      end
      check("midrst_no_held_frame", lowcnt == 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
